// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        LSU_BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_LSU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    localparam int unsigned WORD_BYTES = 4;

    // Clears the byte-offset bits so every access lands on a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_tag.sv
// One-entry read-return tag: remembers who owned last cycle's read beat and
// steers the 1-cycle-latency RAM data to that requester.
module arb_rd_tag
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_i,
    input  owner_t      issue_owner_i,
    input  logic [31:0] mem_rdata_i,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        host_rvalid_o,
    output logic [31:0] host_rdata_o
);

    logic        tag_valid_q;
    owner_t      tag_owner_q;
    logic [31:0] lsu_rdata_q;
    logic [31:0] host_rdata_q;

    assign lsu_rvalid_o  = tag_valid_q && (tag_owner_q == OWN_LSU);
    assign host_rvalid_o = tag_valid_q && (tag_owner_q == OWN_HOST);
    // The non-owner keeps showing its previous read data.
    assign lsu_rdata_o   = lsu_rvalid_o  ? mem_rdata_i : lsu_rdata_q;
    assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : host_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_q  <= 1'b0;
            tag_owner_q  <= OWN_LSU;
            lsu_rdata_q  <= 32'h0000_0000;
            host_rdata_q <= 32'h0000_0000;
        end else begin
            tag_valid_q  <= issue_i;
            tag_owner_q  <= issue_owner_i;
            lsu_rdata_q  <= lsu_rdata_o;
            host_rdata_q <= host_rdata_o;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported data RAM between the LSU (singles and VEC_LEN bursts)
// and the host loader. Optional host starvation guard: ARB_HOST_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned VEC_LEN  = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_req,
    input  logic        lsu_burst,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_gnt,
    output logic [1:0]  lsu_beat,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] LAST_BEAT = 2'(VEC_LEN - 1);

    arb_state_t  state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        rd_issue_s;
    owner_t      rd_owner_s;
    logic        host_starve_s;

`ifdef ARB_HOST_STARVE_GUARD_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;

    assign host_starve_s = (wait_q == WAIT_W'(MAX_WAIT));

    // Saturating count of cycles the host has been kept waiting.
    always_comb begin
        wait_d = wait_q;
        if (!host_req || host_gnt) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign host_starve_s = 1'b0;
`endif

    // Arbitration, beat sequencing and RAM command steering.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        lsu_gnt    = 1'b0;
        host_gnt   = 1'b0;
        lsu_beat   = 2'd0;
        mem_addr   = mem_addr_q;
        mem_we     = 1'b0;
        mem_wdata  = mem_wdata_q;
        rd_issue_s = 1'b0;
        rd_owner_s = OWN_LSU;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (lsu_req && !host_starve_s) begin
                        lsu_gnt    = 1'b1;
                        mem_addr   = word_align(lsu_addr);
                        mem_we     = lsu_we;
                        mem_wdata  = lsu_wdata;
                        rd_issue_s = !lsu_we;
                        if (lsu_burst) begin
                            state_d = LSU_BURST;
                            beat_d  = 2'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (host_req) begin
                        host_gnt   = 1'b1;
                        mem_addr   = word_align(host_addr);
                        mem_we     = host_we;
                        mem_wdata  = host_wdata;
                        rd_issue_s = !host_we;
                        rd_owner_s = OWN_HOST;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LSU_BURST: begin
                    // Bursts run to completion regardless of lsu_req.
                    lsu_gnt    = 1'b1;
                    lsu_beat   = beat_q;
                    mem_addr   = word_align(lsu_addr) + {28'h000_0000, beat_q, 2'b00};
                    mem_we     = lsu_we;
                    mem_wdata  = lsu_wdata;
                    rd_issue_s = !lsu_we;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = 2'd0;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    beat_d  = 2'd0;
                end
            endcase
        end else begin
            state_d = IDLE;
            beat_d  = 2'd0;
        end
    end

    // State, beat counter and held RAM address/data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
        end
    end

    assign busy = (state_q == LSU_BURST);

    arb_rd_tag u_rd_tag (
        .clk           (clk),
        .reset         (reset),
        .issue_i       (rd_issue_s),
        .issue_owner_i (rd_owner_s),
        .mem_rdata_i   (mem_rdata),
        .lsu_rvalid_o  (lsu_rvalid),
        .lsu_rdata_o   (lsu_rdata),
        .host_rvalid_o (host_rvalid),
        .host_rdata_o  (host_rdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (VEC_LEN=4, MAX_WAIT=8).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req, lsu_burst, lsu_we;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_gnt;
    logic [1:0]  lsu_beat;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        host_req, host_we;
    logic [31:0] host_addr, host_wdata;
    logic        host_gnt, host_rvalid;
    logic [31:0] host_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.VEC_LEN(4), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset),
        .lsu_req(lsu_req), .lsu_burst(lsu_burst), .lsu_we(lsu_we),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_gnt(lsu_gnt), .lsu_beat(lsu_beat),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Advance to just after the next rising edge; inputs change here, checks at negedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lsu_req = 1'b0; lsu_burst = 1'b0; lsu_we = 1'b0;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;
        mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({lsu_gnt, host_gnt, lsu_rvalid, host_rvalid, mem_we, busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {lsu_gnt, host_gnt, lsu_rvalid, host_rvalid, mem_we, busy});
        end
        total++;
        if ({mem_addr, mem_wdata, lsu_rdata, host_rdata} !== 128'h0 || lsu_beat !== 2'd0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h lrd=%h hrd=%h beat=%0d want all 0",
                     mem_addr, mem_wdata, lsu_rdata, host_rdata, lsu_beat);
        end
    endtask

    task automatic test_single_read();
        step();
        lsu_req = 1'b1; lsu_burst = 1'b0; lsu_we = 1'b0; lsu_addr = 32'h0000_0100;
        @(negedge clk);
        total++;
        if (lsu_gnt !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || host_gnt !== 1'b0) begin
            bad++;
            $display("FAIL single_gnt: gnt=%b addr=%h we=%b hgnt=%b want 1 00000100 0 0",
                     lsu_gnt, mem_addr, mem_we, host_gnt);
        end
        step();
        idle_inputs();
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'hDEAD_BEEF || host_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL single_rdata: rv=%b rd=%h hrv=%b want 1 deadbeef 0",
                     lsu_rvalid, lsu_rdata, host_rvalid);
        end
        total++;
        if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold_addr: addr=%h we=%b want 00000100 0", mem_addr, mem_we);
        end
        step();
        mem_rdata = 32'h1111_1111;
        @(negedge clk);
        total++;
        if (lsu_rvalid !== 1'b0 || lsu_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL single_hold: rv=%b rd=%h want 0 deadbeef", lsu_rvalid, lsu_rdata);
        end
    endtask

    task automatic test_burst_write();
        for (int k = 0; k < 4; k++) begin
            step();
            lsu_req = 1'b1; lsu_burst = 1'b1; lsu_we = 1'b1;
            lsu_addr = 32'h0000_0203; lsu_wdata = 32'hA + 32'(k);
            @(negedge clk);
            total++;
            if (lsu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== (32'h200 + 32'(4 * k)) ||
                mem_wdata !== (32'hA + 32'(k)) || lsu_beat !== 2'(k) || busy !== (k != 0)) begin
                bad++;
                $display("FAIL burst_wr_beat%0d: gnt=%b we=%b addr=%h wd=%h beat=%0d busy=%b want 1 1 %h %h %0d %b",
                         k, lsu_gnt, mem_we, mem_addr, mem_wdata, lsu_beat, busy,
                         32'h200 + 32'(4 * k), 32'hA + 32'(k), k, k != 0);
            end
        end
        step();
        idle_inputs();
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || lsu_rvalid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h20C) begin
            bad++;
            $display("FAIL burst_wr_end: busy=%b rv=%b we=%b addr=%h want 0 0 0 0000020c",
                     busy, lsu_rvalid, mem_we, mem_addr);
        end
    endtask

    task automatic test_burst_read_wrap();
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0000_0000; exp_addr[3] = 32'h0000_0004;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k < 4) begin
                lsu_req = 1'b1; lsu_burst = 1'b1; lsu_we = 1'b0; lsu_addr = 32'hFFFF_FFF8;
            end else begin
                idle_inputs();
            end
            mem_rdata = 32'h1000 + 32'(k);
            @(negedge clk);
            if (k < 4) begin
                total++;
                if (lsu_gnt !== 1'b1 || mem_addr !== exp_addr[k] || mem_we !== 1'b0) begin
                    bad++;
                    $display("FAIL burst_rd_addr%0d: gnt=%b addr=%h we=%b want 1 %h 0",
                             k, lsu_gnt, mem_addr, mem_we, exp_addr[k]);
                end
            end
            total++;
            if (lsu_rvalid !== (k != 0) || (k != 0 && lsu_rdata !== 32'h1000 + 32'(k))) begin
                bad++;
                $display("FAIL burst_rd_rv%0d: rv=%b rd=%h want %b %h",
                         k, lsu_rvalid, lsu_rdata, k != 0, 32'h1000 + 32'(k));
            end
        end
        step();
        @(negedge clk);
        total++;
        if (lsu_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL burst_rd_tail: rv=%b hrv=%b want 0 0", lsu_rvalid, host_rvalid);
        end
    endtask

    task automatic test_host_during_burst();
        for (int k = 0; k < 4; k++) begin
            step();
            lsu_req = 1'b1; lsu_burst = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h300;
            host_req = 1'b1; host_we = 1'b0; host_addr = 32'h40;
            mem_rdata = 32'h2000 + 32'(k);
            @(negedge clk);
            total++;
            if (host_gnt !== 1'b0 || lsu_gnt !== 1'b1) begin
                bad++;
                $display("FAIL host_blocked%0d: hgnt=%b lgnt=%b want 0 1", k, host_gnt, lsu_gnt);
            end
        end
        step();
        lsu_req = 1'b0; lsu_burst = 1'b0;
        mem_rdata = 32'h1234;
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b1 || mem_addr !== 32'h40 || lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h1234) begin
            bad++;
            $display("FAIL host_after_burst: hgnt=%b addr=%h lrv=%b lrd=%h want 1 00000040 1 00001234",
                     host_gnt, mem_addr, lsu_rvalid, lsu_rdata);
        end
        step();
        idle_inputs();
        mem_rdata = 32'h55;
        @(negedge clk);
        total++;
        if (host_rvalid !== 1'b1 || host_rdata !== 32'h55 || lsu_rvalid !== 1'b0 || lsu_rdata !== 32'h1234) begin
            bad++;
            $display("FAIL host_rdata: hrv=%b hrd=%h lrv=%b lrd=%h want 1 00000055 0 00001234",
                     host_rvalid, host_rdata, lsu_rvalid, lsu_rdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            step();
            if (k < 4) begin
                lsu_req = 1'b1; lsu_burst = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h500;
            end else begin
                lsu_req = 1'b1; lsu_burst = 1'b0; lsu_we = 1'b1; lsu_addr = 32'h600;
                lsu_wdata = 32'h77;
            end
            @(negedge clk);
        end
        total++;
        if (lsu_gnt !== 1'b1 || mem_addr !== 32'h600 || mem_we !== 1'b1 ||
            mem_wdata !== 32'h77 || lsu_rvalid !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_grant: gnt=%b addr=%h we=%b wd=%h rv=%b busy=%b want 1 00000600 1 00000077 1 0",
                     lsu_gnt, mem_addr, mem_we, mem_wdata, lsu_rvalid, busy);
        end
        step();
        idle_inputs();
        @(negedge clk);
        total++;
        if (lsu_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_write_no_rv: rv=%b want 0", lsu_rvalid);
        end
    endtask

    task automatic test_starve();
        int hg_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            lsu_req = 1'b1; lsu_burst = 1'b0; lsu_we = 1'b0; lsu_addr = 32'h10;
            host_req = 1'b1; host_we = 1'b0; host_addr = 32'h80;
            @(negedge clk);
`ifdef ARB_HOST_STARVE_GUARD_EN
            total++;
            if (host_gnt !== (k == 8) || lsu_gnt !== (k != 8)) begin
                bad++;
                $display("FAIL starve_guard%0d: hgnt=%b lgnt=%b want %b %b",
                         k, host_gnt, lsu_gnt, k == 8, k != 8);
            end
`else
            if (host_gnt === 1'b1) hg_seen++;
`endif
        end
`ifndef ARB_HOST_STARVE_GUARD_EN
        total++;
        if (hg_seen !== 0) begin
            bad++;
            $display("FAIL starve_strict: host grants=%0d want 0", hg_seen);
        end
        step();
        lsu_req = 1'b0;
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b1 || mem_addr !== 32'h80) begin
            bad++;
            $display("FAIL starve_release: hgnt=%b addr=%h want 1 00000080", host_gnt, mem_addr);
        end
`endif
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_burst();
        step();
        lsu_req = 1'b1; lsu_burst = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h400;
        @(negedge clk);
        total++;
        if (lsu_gnt !== 1'b1 || lsu_beat !== 2'd0) begin
            bad++;
            $display("FAIL rst_burst_start: gnt=%b beat=%0d want 1 0", lsu_gnt, lsu_beat);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || lsu_gnt !== 1'b0 || lsu_rvalid !== 1'b0 ||
            host_rvalid !== 1'b0 || lsu_beat !== 2'd0) begin
            bad++;
            $display("FAIL rst_mid_burst: busy=%b gnt=%b rv=%b hrv=%b beat=%0d want 0 0 0 0 0",
                     busy, lsu_gnt, lsu_rvalid, host_rvalid, lsu_beat);
        end
        step();
        lsu_req = 1'b1; lsu_burst = 1'b0; lsu_we = 1'b0; lsu_addr = 32'h444;
        @(negedge clk);
        total++;
        if (lsu_gnt !== 1'b1 || mem_addr !== 32'h444 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_recover: gnt=%b addr=%h busy=%b want 1 00000444 0",
                     lsu_gnt, mem_addr, busy);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst_write();
        test_burst_read_wrap();
        test_host_during_burst();
        test_back_to_back();
        test_starve();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported, word-wide data memory between the pipeline load/store unit (LSU) and the host loader port. It sequences LSU vector accesses as atomic bursts of VEC_LEN consecutive words and generates the per-beat addresses. It routes 1-cycle-latency read data back to whichever requester owned the read beat. It sits between the MEM stage/LSU and the data RAM.

## Interface
- VEC_LEN, 4, words per LSU burst (≥2)
- MAX_WAIT, 8, host starvation limit in cycles (only with guard enabled)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- lsu_req  in  1  LSU access request
- lsu_burst  in  1  request is a vector burst (VEC_LEN beats)
- lsu_we  in  1  write (1) / read (0), whole burst
- lsu_addr  in  32  word address (single) / burst base
- lsu_wdata  in  32  write data for current beat
- lsu_gnt  out  1  current LSU beat accepted this cycle
- lsu_beat  out  2  index of beat being issued (0 for single)
- lsu_rvalid  out  1  LSU read data valid
- lsu_rdata  out  32  LSU read data
- host_req, host_we  in  1  host single-word request / write
- host_addr, host_wdata  in  32  host address / write data
- host_gnt  out  1  host beat accepted
- host_rvalid  out  1  host read data valid
- host_rdata  out  32  host read data
- mem_addr  out  32  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid one cycle after address
- busy  out  1  burst in progress

## Operation
- States: IDLE, LSU_BURST.
- IDLE: combinational arbitration. Winner gets gnt in the same cycle; mem_* driven from winner.
  - LSU wins by default. Host wins only if lsu_req=0 or the starvation guard fires.
  - LSU single: one beat, stay IDLE. LSU burst: beat 0 issued, go LSU_BURST with beat counter=1.
- LSU_BURST: lsu_gnt=1 every cycle; mem_addr = {lsu_addr[31:2],2'b00} + {beat,2'b00}, modulo 2^32.
  - lsu_wdata/lsu_we sampled per beat.
  - Host is never granted.
  - After beat VEC_LEN-1 is issued, return to IDLE.
- Bursts are not abortable. lsu_req deasserting mid-burst is a protocol violation; the burst still completes.
- Address low two bits are forced to 0 for all accesses.
- Read return: a registered tag (valid, owner) follows each read beat. Next cycle, the owner's rvalid=1 and its rdata=mem_rdata. The other requester's rdata holds its last value. Writes produce no rvalid.
- No request: mem_we=0; mem_addr holds last value.

## Timing
- Reset values: state IDLE, beat 0, all gnt/rvalid 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, busy 0, wait counter 0.
- Single access: gnt in cycle N, rvalid in N+1.
- Burst: gnt in N..N+VEC_LEN-1, rvalid in N+1..N+VEC_LEN. busy=1 from N+1 to N+VEC_LEN-1.
- Back-to-back: the next request may be granted in the cycle after the last burst beat. Pending rvalid does not block a new grant.
- Reset mid-burst: state returns to IDLE and the pending read tag is cleared; no rvalid in the following cycle.
- Simultaneous lsu_req and host_req in IDLE: LSU granted, unless the guard fires.

## Configuration
- ARB_HOST_STARVE_GUARD_EN defined:
  - A wait counter (saturating at MAX_WAIT) increments each cycle host_req=1 and host_gnt=0. It clears on host_gnt or when host_req=0.
  - When counter==MAX_WAIT in IDLE, host wins over LSU. It never preempts a burst.
- Undefined: strict LSU priority; counter absent; host served only when lsu_req=0 in IDLE.

## Structure
- Shared package: arb_state_t enum {IDLE, LSU_BURST}, owner enum {OWN_LSU, OWN_HOST}, WORD_BYTES=4 constant.
- Submodule: arb_rd_tag (1-entry read-return tag register plus data steering).

## Test plan
- LSU single read addr 0x100, mem returns 0xDEADBEEF → lsu_gnt cycle N; lsu_rvalid=1, lsu_rdata=0xDEADBEEF at N+1; no host_rvalid.
- LSU burst write base 0x203 (aligned to 0x200), wdata 0xA,0xB,0xC,0xD → mem_addr 0x200,0x204,0x208,0x20C on four consecutive cycles with mem_we=1; lsu_beat 0..3; busy=1 for beats 1–3.
- LSU burst read base 0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap); four lsu_rvalid pulses in order.
- Host read 0x40 raised during an LSU burst → host_gnt only in the cycle after the last burst beat; host_rvalid one cycle later.
- With guard, MAX_WAIT=8, lsu_req held with single reads and host_req held → host_gnt after exactly 8 waiting cycles, then LSU resumes. Without guard → host never granted while lsu_req=1.
- reset asserted at burst beat 1 → next cycle state IDLE, no gnt, no rvalid, busy=0.
